// File: rtl/buf_write_ctrl.sv
// Ingress frame writer: stores frames as linked 32-word cells in the packet buffer and emits one descriptor per stored frame.
// Latency: buffer and link writes land 1 cycle after the word handshake; desc_valid rises with the final buf_wr.
// Backpressure: i_ready drops for 1 bubble per cell boundary, while the free queue is empty, and until the descriptor is taken.
// Option BUF_WR_ERR_DROP_EN: frames with i_err at EOP are released instead of forwarded.
module buf_write_ctrl #(
  parameter int CELL_AW   = 5,
  parameter int MAX_CELLS = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        i_data,
  input  logic               i_valid,
  input  logic               i_sop,
  input  logic               i_eop,
  input  logic [3:0]         i_dport,
  input  logic               i_err,
  output logic               i_ready,
  input  logic [9:0]         fq_ptr,
  input  logic               fq_empty,
  output logic               fq_rd,
  output logic               fq_ret_wr,
  output logic [9:0]         fq_ret_ptr,
  output logic               buf_wr,
  output logic [9+CELL_AW-1:0] buf_addr,
  output logic [31:0]        buf_din,
  output logic               lnk_wr,
  output logic [9:0]         lnk_addr,
  output logic [9:0]         lnk_din,
  output logic               desc_valid,
  input  logic               desc_ready,
  output logic [9:0]         desc_head,
  output logic [8:0]         desc_words,
  output logic [3:0]         desc_cells,
  output logic [3:0]         desc_dport
);

  localparam logic [9:0] END_PTR = 10'h3FF;
  localparam logic [3:0] MAX_C   = 4'(MAX_CELLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOP,
    S_WRITE,
    S_NEXT,
    S_DESC,
    S_RELEASE
  } state_t;

  state_t state, state_n;

  logic [9:0]         cur;
  logic [9:0]         head;
  logic [9:0]         list [MAX_CELLS];
  logic [3:0]         cells;
  logic [3:0]         rel_idx;
  logic [3:0]         dport;
  logic [CELL_AW-1:0] word_cnt;
  logic [8:0]         words;
  logic               drop;
  logic               accept;
  logic               cell_last;
  logic               err_drop;

`ifdef BUF_WR_ERR_DROP_EN
  assign err_drop = i_err;
`else
  logic unused_err;
  assign unused_err = i_err;
  assign err_drop   = 1'b0;
`endif

  assign i_ready   = (state == S_SOP) || (state == S_WRITE);
  assign accept    = i_valid && i_ready;
  assign cell_last = &word_cnt;

  // Gated by rst so no pop is requested while the free queue itself is in reset.
  assign fq_rd = rst && !fq_empty &&
                 ((state == S_IDLE) || ((state == S_NEXT) && (cells != MAX_C)));

  assign desc_valid = (state == S_DESC);
  assign fq_ret_wr  = (state == S_RELEASE);
  assign fq_ret_ptr = fq_ret_wr ? list[rel_idx] : 10'h000;

  assign desc_head  = head;
  assign desc_words = words;
  assign desc_cells = cells;
  assign desc_dport = dport;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (fq_rd) state_n = S_SOP;
      end
      S_SOP: begin
        if (accept && i_sop) begin
          if (i_eop) state_n = err_drop ? S_RELEASE : S_DESC;
          else       state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        if (accept) begin
          if (i_eop)                   state_n = (drop || err_drop) ? S_RELEASE : S_DESC;
          else if (!drop && cell_last) state_n = S_NEXT;
        end
      end
      S_NEXT: begin
        if (!fq_empty) state_n = S_WRITE;
      end
      S_DESC: begin
        if (desc_ready) state_n = S_IDLE;
      end
      S_RELEASE: begin
        if (rel_idx == cells - 4'd1) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur      <= '0;
      head     <= '0;
      cells    <= '0;
      rel_idx  <= '0;
      dport    <= '0;
      word_cnt <= '0;
      words    <= '0;
      drop     <= 1'b0;
      buf_wr   <= 1'b0;
      buf_addr <= '0;
      buf_din  <= '0;
      lnk_wr   <= 1'b0;
      lnk_addr <= '0;
      lnk_din  <= '0;
      for (int i = 0; i < MAX_CELLS; i++) list[i] <= '0;
    end else begin
      buf_wr <= 1'b0;
      lnk_wr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fq_rd) begin
            cur      <= fq_ptr;
            head     <= fq_ptr;
            list[0]  <= fq_ptr;
            cells    <= 4'd1;
            rel_idx  <= '0;
            word_cnt <= '0;
            words    <= '0;
            drop     <= 1'b0;
          end
        end
        S_SOP: begin
          // Words before the first SOP are swallowed without touching the buffer.
          if (accept && i_sop) begin
            buf_wr   <= 1'b1;
            buf_addr <= {cur[8:0], {CELL_AW{1'b0}}};
            buf_din  <= i_data;
            dport    <= i_dport;
            word_cnt <= CELL_AW'(1);
            words    <= 9'd1;
            if (i_eop) begin
              lnk_wr   <= 1'b1;
              lnk_addr <= cur;
              lnk_din  <= END_PTR;
            end
          end
        end
        S_WRITE: begin
          if (accept && !drop) begin
            buf_wr   <= 1'b1;
            buf_addr <= {cur[8:0], word_cnt};
            buf_din  <= i_data;
            word_cnt <= word_cnt + CELL_AW'(1);
            words    <= words + 9'd1;
            if (i_eop) begin
              lnk_wr   <= 1'b1;
              lnk_addr <= cur;
              lnk_din  <= END_PTR;
            end
          end
        end
        S_NEXT: begin
          if (!fq_empty) begin
            if (cells == MAX_C) begin
              // Oversize: keep draining the frame but stop writing; its cells are released at EOP.
              drop <= 1'b1;
            end else begin
              lnk_wr       <= 1'b1;
              lnk_addr     <= cur;
              lnk_din      <= fq_ptr;
              cur          <= fq_ptr;
              list[cells]  <= fq_ptr;
              cells        <= cells + 4'd1;
              word_cnt     <= '0;
            end
          end
        end
        S_RELEASE: begin
          rel_idx <= rel_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_buf_write_ctrl.sv
// Directed bench for buf_write_ctrl: table of frame vectors plus free-queue stall and descriptor-hold sequences.
module tb_buf_write_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] i_data = '0;
  logic        i_valid = 1'b0;
  logic        i_sop = 1'b0;
  logic        i_eop = 1'b0;
  logic [3:0]  i_dport = '0;
  logic        i_err = 1'b0;
  logic        i_ready;
  logic [9:0]  fq_ptr;
  logic        fq_empty;
  logic        fq_rd;
  logic        fq_ret_wr;
  logic [9:0]  fq_ret_ptr;
  logic        buf_wr;
  logic [13:0] buf_addr;
  logic [31:0] buf_din;
  logic        lnk_wr;
  logic [9:0]  lnk_addr;
  logic [9:0]  lnk_din;
  logic        desc_valid;
  logic        desc_ready = 1'b1;
  logic [9:0]  desc_head;
  logic [8:0]  desc_words;
  logic [3:0]  desc_cells;
  logic [3:0]  desc_dport;

  always #5 clk = ~clk;

  buf_write_ctrl dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_sop(i_sop),
    .i_eop(i_eop), .i_dport(i_dport), .i_err(i_err), .i_ready(i_ready),
    .fq_ptr(fq_ptr), .fq_empty(fq_empty), .fq_rd(fq_rd), .fq_ret_wr(fq_ret_wr),
    .fq_ret_ptr(fq_ret_ptr), .buf_wr(buf_wr), .buf_addr(buf_addr), .buf_din(buf_din),
    .lnk_wr(lnk_wr), .lnk_addr(lnk_addr), .lnk_din(lnk_din), .desc_valid(desc_valid),
    .desc_ready(desc_ready), .desc_head(desc_head), .desc_words(desc_words),
    .desc_cells(desc_cells), .desc_dport(desc_dport)
  );

  typedef struct {
    int         len;
    int         junk;
    logic [3:0] dport;
    logic       err;
    int         desc;
    int         words;
    int         cells;
    int         pops;
    int         rets;
    int         bufwr;
    int         lnks;
    int         term;
  } vec_t;

  int tests = 0;
  int failed = 0;
  int tmo = 0;

  // Free-queue model: FWFT queue, refilled with 0..511 while fq_reinit is high.
  int         fq[$];
  int         fq_cnt = 0;
  logic       fq_reinit = 1'b0;
  logic       force_empty = 1'b0;
  logic       pend_pop = 1'b0;
  logic       pend_ret = 1'b0;
  logic [9:0] pend_ptr = '0;
  assign fq_empty = (fq_cnt == 0) || force_empty;

  initial forever begin
    @(posedge clk);
    #1;
    if (fq_reinit) begin
      fq.delete();
      for (int i = 0; i < 512; i++) fq.push_back(i);
    end else begin
      if (pend_pop && fq.size() > 0) void'(fq.pop_front());
      if (pend_ret) fq.push_back(int'(pend_ptr));
    end
    fq_cnt = fq.size();
    fq_ptr = (fq.size() > 0) ? 10'(fq[0]) : 10'h000;
  end

  // Output monitor, sampled mid low phase.
  logic [31:0] bmem [int];
  logic [9:0]  lnk_a[$];
  logic [9:0]  lnk_d[$];
  logic [9:0]  rets[$];
  int          nbuf, npop, ndesc, rise_bad, overlap, ready_viol;
  int          cyc = 0;
  int          ret_first, ret_last;
  logic [9:0]  d_head;
  logic [8:0]  d_words;
  logic [3:0]  d_cells, d_dport;
  logic        prev_dv = 1'b0;
  logic        clr_req = 1'b0;

  initial forever begin
    @(negedge clk);
    #2;
    cyc++;
    if (clr_req) begin
      bmem.delete(); lnk_a.delete(); lnk_d.delete(); rets.delete();
      nbuf = 0; npop = 0; ndesc = 0; rise_bad = 0; overlap = 0; ready_viol = 0;
      ret_first = -1; ret_last = -1;
      d_head = '0; d_words = '0; d_cells = '0; d_dport = '0;
    end else begin
      if (buf_wr) begin bmem[int'(buf_addr)] = buf_din; nbuf++; end
      if (lnk_wr) begin lnk_a.push_back(lnk_addr); lnk_d.push_back(lnk_din); end
      if (fq_rd) npop++;
      if (fq_ret_wr) begin
        rets.push_back(fq_ret_ptr);
        if (ret_first < 0) ret_first = cyc;
        ret_last = cyc;
      end
      if (desc_valid && !prev_dv && !buf_wr) rise_bad++;
      if (desc_valid && fq_ret_wr) overlap++;
      if (force_empty && i_ready) ready_viol++;
      if (desc_valid && desc_ready) begin
        ndesc++;
        d_head = desc_head; d_words = desc_words; d_cells = desc_cells; d_dport = desc_dport;
      end
    end
    prev_dv  = desc_valid;
    pend_pop = fq_rd;
    pend_ret = fq_ret_wr;
    pend_ptr = fq_ret_ptr;
  end

  int stall_before [512];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int fid, input int j);
    return {fid[7:0], 8'h5A, j[15:0]};
  endfunction

  task automatic do_reset(input bit chk);
    @(negedge clk);
    rst = 1'b0; fq_reinit = 1'b1; clr_req = 1'b1;
    i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0; force_empty = 1'b0;
    @(negedge clk);
    #3;
    if (chk) begin
      // Queue is full here, so fq_rd must still be held low by reset.
      check("rst_i_ready", 32'(i_ready), 0);
      check("rst_fq_rd", 32'(fq_rd), 0);
      check("rst_buf_wr", 32'(buf_wr), 0);
      check("rst_lnk_wr", 32'(lnk_wr), 0);
      check("rst_desc_valid", 32'(desc_valid), 0);
      check("rst_fq_ret_wr", 32'(fq_ret_wr), 0);
      check("rst_lnk_din", 32'(lnk_din), 0);
      check("rst_fq_ret_ptr", 32'(fq_ret_ptr), 0);
      check("rst_desc_fields", {desc_head, desc_words, desc_cells, desc_dport}, 0);
    end
    fq_reinit = 1'b0; clr_req = 1'b0; tmo = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic send_frame(input int len, input int junk, input logic [3:0] dp,
                            input logic er, input int fid, input int force_word);
    int budget;
    int waited;
    int fcnt = 0;
    for (int j = -junk; j < len; j++) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_sop   = (j == 0);
      i_eop   = (j == len - 1);
      i_dport = (j == 0) ? dp : 4'h0;
      i_err   = (j == len - 1) ? er : 1'b0;
      i_data  = pat(fid, j);
      if (j == force_word) begin force_empty = 1'b1; fcnt = 0; end
      budget = 300;
      waited = 0;
      while (!i_ready && budget > 0) begin
        @(negedge clk);
        budget--; waited++;
        if (force_empty) begin
          fcnt++;
          if (fcnt >= 20) force_empty = 1'b0;
        end
      end
      if (budget == 0) tmo++;
      if (j >= 0) stall_before[j] = waited;
    end
    @(negedge clk);
    i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_err = 1'b0; force_empty = 1'b0;
  endtask

  task automatic check_vec(input string tag, input vec_t v, input int h, input int fid, input bit chk_stall);
    int bad;
    check({tag, "_desc_cnt"}, ndesc, v.desc);
    if (v.desc != 0) begin
      check({tag, "_desc_head"}, 32'(d_head), h);
      check({tag, "_desc_words"}, 32'(d_words), v.words);
      check({tag, "_desc_cells"}, 32'(d_cells), v.cells);
      check({tag, "_desc_dport"}, 32'(d_dport), 32'(v.dport));
    end
    // Includes the pop that re-arms IDLE for the next frame.
    check({tag, "_pops"}, npop, v.pops + 1);
    check({tag, "_ret_cnt"}, rets.size(), v.rets);
    bad = 0;
    foreach (rets[k]) if (rets[k] !== 10'(h + k)) bad++;
    check({tag, "_ret_ptrs"}, bad, 0);
    if (v.rets > 0) check({tag, "_ret_span"}, ret_last - ret_first, v.rets - 1);
    check({tag, "_buf_wr_cnt"}, nbuf, v.bufwr);
    bad = 0;
    for (int i = 0; i < v.bufwr; i++) begin
      int a;
      a = h * 32 + i;
      if (!bmem.exists(a)) bad++;
      else if (bmem[a] !== pat(fid, i)) bad++;
    end
    check({tag, "_buf_data"}, bad, 0);
    check({tag, "_lnk_cnt"}, lnk_a.size(), v.lnks);
    bad = 0;
    for (int k = 0; k < lnk_a.size() && k < v.lnks; k++) begin
      logic [9:0] en;
      en = (k == v.lnks - 1 && v.term != 0) ? 10'h3FF : 10'(h + k + 1);
      if (lnk_a[k] !== 10'(h + k) || lnk_d[k] !== en) bad++;
    end
    check({tag, "_lnk_data"}, bad, 0);
    if (chk_stall) begin
      bad = 0;
      for (int i = 1; i < v.len; i++) if (stall_before[i] != ((i % 32 == 0) ? 1 : 0)) bad++;
      check({tag, "_bubbles"}, bad, 0);
    end
    check({tag, "_desc_rise"}, rise_bad, 0);
    check({tag, "_desc_ret_overlap"}, overlap, 0);
    check({tag, "_timeouts"}, tmo, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt [7];
    vec_t vs;
    int   hold_bad;
    int   b;
    //          len junk dport err   desc words cells pops rets bufwr lnks term
    vt[0] = '{ 10,  0, 4'd3,  1'b0, 1,   10,   1,    1,   0,   10,   1,   1};
    vt[1] = '{ 33,  0, 4'd5,  1'b0, 1,   33,   2,    2,   0,   33,   2,   1};
    vt[2] = '{400,  0, 4'd1,  1'b0, 0,    0,   0,   12,  12,  384,  11,   0};
`ifdef BUF_WR_ERR_DROP_EN
    vt[3] = '{ 40,  0, 4'd7,  1'b1, 0,    0,   0,    2,   2,   40,   2,   1};
`else
    vt[3] = '{ 40,  0, 4'd7,  1'b1, 1,   40,   2,    2,   0,   40,   2,   1};
`endif
    vt[4] = '{  1,  2, 4'd15, 1'b0, 1,    1,   1,    1,   0,    1,   1,   1};
    vt[5] = '{384,  0, 4'd2,  1'b0, 1,  384,  12,   12,   0,  384,  12,   1};
    vt[6] = '{ 32,  0, 4'd4,  1'b0, 1,   32,   1,    1,   0,   32,   1,   1};

    for (int v = 0; v < 7; v++) begin
      do_reset(v < 2);
      send_frame(vt[v].len, vt[v].junk, vt[v].dport, vt[v].err, v + 1, -1);
      repeat (30) @(negedge clk);
      check_vec($sformatf("v%0d", v), vt[v], 0, v + 1, 1'b1);
    end

    // Free queue empty across a cell boundary for 20 cycles.
    do_reset(1'b0);
    vs = '{40, 0, 4'd6, 1'b0, 1, 40, 2, 2, 0, 40, 2, 1};
    send_frame(40, 0, 4'd6, 1'b0, 20, 32);
    repeat (30) @(negedge clk);
    check("stall_ready_low", ready_viol, 0);
    check("stall_len_ok", 32'(stall_before[32] >= 20), 1);
    check_vec("stall", vs, 0, 20, 1'b0);

    // Descriptor held 50 cycles while a second frame is offered.
    do_reset(1'b0);
    desc_ready = 1'b0;
    send_frame(10, 0, 4'd9, 1'b0, 30, -1);
    fork
      send_frame(5, 0, 4'd12, 1'b0, 31, -1);
      begin
        b = 100;
        while (!desc_valid && b > 0) begin @(negedge clk); b--; end
        check("hold_desc_seen", 32'(desc_valid), 1);
        hold_bad = 0;
        repeat (50) begin
          @(negedge clk);
          if (!desc_valid || i_ready || desc_head !== 10'd0 || desc_words !== 9'd10 ||
              desc_cells !== 4'd1 || desc_dport !== 4'd9) hold_bad++;
        end
        check("hold_stable", hold_bad, 0);
        check("hold_no_new_writes", nbuf, 10);
        desc_ready = 1'b1;
      end
    join
    repeat (30) @(negedge clk);
    check("hold_desc_cnt", ndesc, 2);
    check("hold_f2_head", 32'(d_head), 1);
    check("hold_f2_words", 32'(d_words), 5);
    check("hold_f2_dport", 32'(d_dport), 12);
    check("hold_total_wr", nbuf, 15);
    b = 0;
    for (int i = 0; i < 5; i++) begin
      if (!bmem.exists(32 + i)) b++;
      else if (bmem[32 + i] !== pat(31, i)) b++;
    end
    check("hold_f2_data", b, 0);
    check("hold_timeouts", tmo, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/buf_write_ctrl.md
# buf_write_ctrl

Ingress frame writer that consumes free cell pointers from the free-pointer queue (`address_assign`, first-word-fall-through FIFO) and writes each frame into the shared packet buffer as a linked list of cells. It is the stage directly downstream of the free queue. It emits one descriptor per stored frame to the output-queue stage. Pointers of dropped frames go straight back to the free queue's write port.

## Interface
- `CELL_AW`, 5: log2 of words per cell; 32 words of 32 bits, i.e. 128 B.
- `MAX_CELLS`, 12: maximum cells per frame.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `i_data`  in  32  frame word.
- `i_valid`  in  1  word valid.
- `i_sop` / `i_eop`  in  1  first / last word of frame.
- `i_dport`  in  4  destination port; sampled with `i_sop`.
- `i_err`  in  1  frame bad; sampled with `i_eop`.
- `i_ready`  out  1  word accepted when `i_valid && i_ready`.
- `fq_ptr`  in  10  head of free queue (FWFT).
- `fq_empty`  in  1  free queue empty.
- `fq_rd`  out  1  pop free queue; asserted only when `!fq_empty`.
- `fq_ret_wr`  out  1  return pointer; drives free-queue `FQ_wr`.
- `fq_ret_ptr`  out  10  returned pointer; drives `ptr_din[9:0]`.
- `buf_wr`  out  1  buffer write strobe.
- `buf_addr`  out  9+CELL_AW  `{ptr[8:0], word}`.
- `buf_din`  out  32  buffer write data.
- `lnk_wr`  out  1  link RAM write strobe.
- `lnk_addr`  out  10  link RAM address (current cell).
- `lnk_din`  out  10  next pointer; `10'h3FF` = end of list.
- `desc_valid`  out  1  descriptor valid.
- `desc_ready`  in  1  descriptor taken.
- `desc_head`  out  10  first cell pointer.
- `desc_words`  out  9  frame length in words.
- `desc_cells`  out  4  cell count.
- `desc_dport`  out  4  destination port.

## Operation
- States: IDLE, SOP, WRITE, NEXT, DESC, RELEASE.
- IDLE: if `!fq_empty`, pulse `fq_rd`, load `cur = head = fq_ptr`, set `list[0]`, set cells=1, then go to SOP.
- SOP: `i_ready=1`. Non-SOP words are accepted and discarded. A SOP word is written at word 0, `dport` is latched, and the state goes to WRITE. A SOP+EOP word handles as EOP below.
- WRITE: `i_ready=1`. Each accepted word goes to `{cur, word_cnt}`, and `word_cnt` increments.
  - A last-word-of-cell without EOP goes to NEXT.
  - On EOP: write link `cur -> 3FF`. If error-drop is active, go to RELEASE; else go to DESC.
- NEXT: `i_ready=0`. Wait for `!fq_empty`.
  - If cells==MAX_CELLS: oversize. Set `drop`, do not pop, and go to WRITE in discard mode. Discard mode accepts words with no `buf_wr` and no link writes until EOP, then goes to RELEASE.
  - Otherwise: pulse `fq_rd`, write link `cur -> fq_ptr`, set `cur=fq_ptr`, `list[cells]=fq_ptr`, cells++, `word_cnt=0`, then go to WRITE.
- DESC: hold descriptor fields with `desc_valid=1` until `desc_ready`, then go to IDLE.
- RELEASE: one `fq_ret_wr` per cycle with `fq_ret_ptr=list[k]`, for k=0..cells-1, then go to IDLE. The link RAM is not cleared.
- Arithmetic: `word_cnt` is CELL_AW bits and wraps at cell end. `desc_words` equals the accepted word count of the frame, max 384.

## Timing
- Reset values:
  - all outputs 0, including `i_ready`, `fq_rd`, `buf_wr`, `lnk_wr`, `desc_valid`, `fq_ret_wr`;
  - `lnk_din`/`fq_ret_ptr`/`desc_*` = 0;
  - state IDLE.
- Reset mid-frame abandons the frame. Held pointers are not returned, because the free queue re-initialises on the same reset.
- `buf_wr/addr/din` and `lnk_*` are registered: asserted the cycle after the accepting handshake.
- `fq_rd` is combinational from state and `fq_empty`. The pointer is captured on the same edge.
- `desc_valid` rises the cycle after EOP acceptance, coincident with the final `buf_wr`. The buffer is never read before data lands.
- Each cell boundary costs exactly 1 bubble cycle when the free queue is non-empty. An empty free queue stalls in NEXT/IDLE indefinitely with `i_ready=0`.
- `desc_valid` and `fq_ret_wr` are never asserted together.

## Configuration
- `BUF_WR_ERR_DROP_EN` defined: `i_err` at EOP causes RELEASE of all frame cells and no descriptor.
- Undefined: `i_err` is ignored and the frame is forwarded normally. Oversize drop is always active.

## Test plan
- Reset, fq holds ptr 0x000..0x1FF, then a 10-word frame with dport=3:
  - `buf_addr` 0x0000..0x0009;
  - link 0x000->0x3FF;
  - descriptor head=0, words=10, cells=1, dport=3.
- 33-word frame:
  - link 0x000->0x001, then 0x001->0x3FF;
  - one `i_ready` bubble after word 32;
  - descriptor words=33, cells=2.
- 400-word frame:
  - exactly 12 pops;
  - RELEASE returns ptrs 0..11 on 12 consecutive `fq_ret_wr` cycles;
  - no descriptor.
- `BUF_WR_ERR_DROP_EN` defined, 40-word frame with `i_err`: ptrs of both cells returned, no `desc_valid`. Undefined: descriptor words=40.
- `fq_empty` forced high at a cell boundary for 20 cycles: `i_ready=0` throughout, with no data loss or duplication after release.
- `desc_ready` held low 50 cycles: descriptor fields stable, `i_ready=0`, and the next frame starts only after the handshake.
